// File: rtl/data_com_pkg.sv
// Shared definitions for the ping-pong line-buffer read side.
//   clogb2        : bits needed to hold a value (address width helper)
//   state_t       : read controller state encoding
//   PACK_ODD_HIGH : pixel-pair packing order on the output stream
//                   (1 = {odd, even}, odd pixel in the upper half)
package data_com_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam bit PACK_ODD_HIGH = 1'b1;

  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    if (n < 1) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/data_send_if.sv
// Output pixel-pair stream (valid/ready).
//   m_valid : beat valid            (master -> slave)
//   m_ready : downstream accept     (slave -> master)
//   m_data  : {odd pixel, even pixel}
//   m_last  : final beat of a line
interface data_send_if #(
  parameter int VIDEO_DATA_WIDTH = 18
);
  logic                          m_valid;
  logic                          m_ready;
  logic [2*VIDEO_DATA_WIDTH-1:0] m_data;
  logic                          m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/data_send_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO used as the output skid buffer.
//   clk, rst        : clock, async active-high reset (FIFO empties)
//   wr_en, wr_data  : push (ignored when full)
//   rd_en, rd_data  : pop (ignored when empty); rd_data is the head, 0 when empty
//   count/full/empty: occupancy status
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  // Gate the head so the output bus reads 0 while nothing is held.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_send.sv
// data_send: read-side controller for the ping-pong line buffer in data_save.
// Picks the bank holding a completed line (pp_flagr), reads even pixels on
// port A and odd pixels on port B, and streams {odd, even} pairs out through
// a skid FIFO. buf_free pulses once a bank has been fully delivered.
//
// Ports:
//   clk, sclr           : clock, async active-high reset
//   line_rdy            : pulse, one more bank has been written
//   pp_flagr            : bank select (1 = ram1, 0 = ram0)
//   ena_s/enb_s         : RAM read enables
//   addra_s/addrb_s     : even / odd pixel addresses
//   douta_s/doutb_s     : RAM read data, RD_LATENCY after enable
//   strm (master)       : output pixel-pair stream
//   buf_free            : one-cycle pulse, bank released
//   ovf                 : sticky, line_rdy seen with two lines already pending
//   busy                : controller not idle
//   tp_en               : only with DATA_SEND_TEST_PATTERN_EN defined; replaces
//                         pixel data with the pixel indices {2k+1, 2k}
//
// State  | meaning
// IDLE   | no line pending
// START  | flip bank, rewind addresses, consume one pending line
// READ   | issue one read pair per cycle while FIFO credit allows
// DRAIN  | wait for the last beat of the line to be accepted
module data_send
  import data_com_pkg::*;
#(
  parameter  int VIDEO_DATA_WIDTH = 18,
  parameter  int RAM_DEPTH        = 100,
  parameter  int LINE_LEN         = 100,
  parameter  int RD_LATENCY       = 2,
  parameter  int FIFO_DEPTH       = 4,
  localparam int ADDR_WIDTH       = clogb2(RAM_DEPTH - 1)
) (
  input  logic                        clk,
  input  logic                        sclr,
  input  logic                        line_rdy,
  output logic                        pp_flagr,
  output logic                        ena_s,
  output logic                        enb_s,
  output logic [ADDR_WIDTH-1:0]       addra_s,
  output logic [ADDR_WIDTH-1:0]       addrb_s,
  input  logic [VIDEO_DATA_WIDTH-1:0] douta_s,
  input  logic [VIDEO_DATA_WIDTH-1:0] doutb_s,
  data_send_if.master                 strm,
  output logic                        buf_free,
  output logic                        ovf,
`ifdef DATA_SEND_TEST_PATTERN_EN
  input  logic                        tp_en,
`endif
  output logic                        busy
);

  localparam int FW = 2 * VIDEO_DATA_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                      state;
  logic [1:0]                  pend;
  logic [RD_LATENCY-1:0]       pv;
  logic [RD_LATENCY-1:0]       pl;
  logic [CW-1:0]               fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FW-1:0]               fifo_wdata;
  logic [FW-1:0]               fifo_rdata;
  logic [VIDEO_DATA_WIDTH-1:0] even_px;
  logic [VIDEO_DATA_WIDTH-1:0] odd_px;
  logic                        issue;
  logic                        last_pair;
  logic                        line_start;
  logic                        beat_acc;
  logic                        drain_done;

`ifdef DATA_SEND_TEST_PATTERN_EN
  logic [ADDR_WIDTH-1:0]       pa [RD_LATENCY];
`endif

  // Credit counts every read still in the pipe so that all of them, plus the
  // one being issued, are guaranteed a FIFO slot even if nothing is popped.
  assign issue      = (state == S_READ) && !fifo_full &&
                      (int'(fifo_count) + $countones(pv) + 1 <= FIFO_DEPTH);
  assign ena_s      = issue;
  assign enb_s      = issue;
  assign last_pair  = (addra_s == ADDR_WIDTH'(LINE_LEN - 2));
  assign line_start = (state == S_START);
  assign beat_acc   = strm.m_valid & strm.m_ready;
  assign drain_done = (state == S_DRAIN) && (pv == '0) && beat_acc && strm.m_last;

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      pend <= 2'd0;
      ovf  <= 1'b0;
    end else begin
      case ({line_rdy, line_start})
        2'b10: begin
          if (pend == 2'd2) ovf <= 1'b1;
          else              pend <= pend + 2'd1;
        end
        2'b01:   pend <= pend - 2'd1;
        default: pend <= pend;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state    <= S_IDLE;
      pp_flagr <= 1'b1;
      addra_s  <= '0;
      addrb_s  <= '0;
      buf_free <= 1'b0;
      busy     <= 1'b0;
    end else begin
      buf_free <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend != 2'd0) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          pp_flagr <= ~pp_flagr;
          addra_s  <= '0;
          addrb_s  <= ADDR_WIDTH'(1);
          state    <= S_READ;
        end
        S_READ: begin
          if (issue) begin
            if (last_pair) begin
              state <= S_DRAIN;
            end else begin
              addra_s <= addra_s + ADDR_WIDTH'(2);
              addrb_s <= addrb_s + ADDR_WIDTH'(2);
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            buf_free <= 1'b1;
            if (pend != 2'd0) begin
              state <= S_START;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shadow of the RAM read pipeline: a bit reaches the end exactly when the
  // matching douta_s/doutb_s are valid.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      pv <= '0;
      pl <= '0;
    end else begin
      pv[0] <= issue;
      pl[0] <= issue & last_pair;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end

`ifdef DATA_SEND_TEST_PATTERN_EN
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      for (int i = 0; i < RD_LATENCY; i++) pa[i] <= '0;
    end else begin
      pa[0] <= addra_s;
      for (int i = 1; i < RD_LATENCY; i++) pa[i] <= pa[i-1];
    end
  end
`endif

  always_comb begin
    even_px = douta_s;
    odd_px  = doutb_s;
`ifdef DATA_SEND_TEST_PATTERN_EN
    if (tp_en) begin
      even_px = VIDEO_DATA_WIDTH'(pa[RD_LATENCY-1]);
      odd_px  = VIDEO_DATA_WIDTH'(pa[RD_LATENCY-1]) + VIDEO_DATA_WIDTH'(1);
    end
`endif
    if (PACK_ODD_HIGH) fifo_wdata = {pl[RD_LATENCY-1], odd_px, even_px};
    else               fifo_wdata = {pl[RD_LATENCY-1], even_px, odd_px};
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (sclr),
    .wr_en   (pv[RD_LATENCY-1]),
    .wr_data (fifo_wdata),
    .rd_en   (strm.m_ready),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign strm.m_valid = ~fifo_empty;
  assign strm.m_data  = fifo_rdata[2*VIDEO_DATA_WIDTH-1:0];
  assign strm.m_last  = fifo_rdata[2*VIDEO_DATA_WIDTH];

endmodule
